// File: rtl/synth_float_pkg.sv
// Shared float-format constants, the float32 bit layout and the int_to_float FSM states.
package synth_float_pkg;

  localparam int FLT_EXP_W  = 8;
  localparam int FLT_MANT_W = 23;
  localparam int FLT_BIAS   = 127;

  typedef struct packed {
    logic                  sign;
    logic [FLT_EXP_W-1:0]  exp;
    logic [FLT_MANT_W-1:0] mant;
  } float32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } itof_state_t;

endpackage

// File: rtl/itof_pack.sv
// Combinational rounding/packing of a normalised magnitude into an IEEE-754 single.
// Define ITOF_ROUND_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module itof_pack
  import synth_float_pkg::*;
#(
  parameter int MAG_W = 16
) (
  input  logic                 sign,
  input  logic [MAG_W-1:0]     mag,
  input  logic [FLT_EXP_W-1:0] exp,
  output float32_t             result
);

`ifdef ITOF_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic [31:0]         w_al;
  logic                w_guard;
  logic                w_sticky;
  logic                w_inc;
  logic [FLT_MANT_W:0] w_sum;

  // Left-align so the hidden one sits at bit 31 whatever MAG_W is.
  assign w_al     = 32'(mag) << (32 - MAG_W);
  assign w_guard  = w_al[7];
  assign w_sticky = |w_al[6:0];
  assign w_inc    = ROUND_EN & w_guard & (w_sticky | w_al[8]);
  assign w_sum    = {1'b0, w_al[30:8]} + {23'd0, w_inc};

  // A clear hidden bit only happens for a zero input, which packs to +0.
  always_comb begin
    result = '0;
    if (w_al[31]) begin
      result.sign = sign;
      result.exp  = exp + {7'd0, w_sum[FLT_MANT_W]};
      result.mant = w_sum[FLT_MANT_W-1:0];
    end else begin
      result = '0;
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Iterative signed-integer to IEEE-754 single converter, one bit of normalisation per cycle.
// Rounding behaviour is selected in itof_pack by the ITOF_ROUND_EN macro.
module int_to_float
  import synth_float_pkg::*;
#(
  parameter int INT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WIDTH-1:0] intin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          floatout
);

  localparam logic [FLT_EXP_W-1:0] EXP_INIT = 8'(FLT_BIAS + INT_WIDTH - 1);
  localparam logic [INT_WIDTH-1:0] ONE      = INT_WIDTH'(1);

  itof_state_t          r_state;
  logic                 r_sign;
  logic [INT_WIDTH-1:0] r_mag;
  logic [7:0]           r_exp;
  logic [31:0]          r_floatout;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [INT_WIDTH-1:0] w_mag_in;
  float32_t             w_packed;

  assign w_mag_in  = intin[INT_WIDTH-1] ? (~intin + ONE) : intin;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign floatout  = r_floatout;

  itof_pack #(
    .MAG_W (INT_WIDTH)
  ) u_pack (
    .sign   (r_sign),
    .mag    (r_mag),
    .exp    (r_exp),
    .result (w_packed)
  );

  // Zero skips NORM and goes straight to PACK, which emits +0 one cycle after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_exp       <= 8'd0;
      r_floatout  <= 32'h0000_0000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign     <= intin[INT_WIDTH-1];
            r_mag      <= w_mag_in;
            r_exp      <= EXP_INIT;
            r_in_ready <= 1'b0;
            r_state    <= (intin == '0) ? PACK : NORM;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        NORM: begin
          if (r_mag[INT_WIDTH-1]) begin
            r_state <= PACK;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        PACK: begin
          r_floatout  <= w_packed;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: 16-bit instance plus a 32-bit instance for rounding cases.
module tb_int_to_float;

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] intin = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] floatout;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] intin32 = 32'h0;
  logic        out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] floatout32;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  int_to_float #(.INT_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .intin     (intin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .floatout  (floatout)
  );

  int_to_float #(.INT_WIDTH(32)) dut32 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .intin     (intin32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .floatout  (floatout32)
  );

  function automatic logic [31:0] model16(input logic [15:0] x);
    logic s;
    int   m;
    int   e;
    if (x == 16'h0000) return 32'h0;
    s = x[15];
    m = s ? (65536 - int'(x)) : int'(x);
    e = 15;
    while (m[e] == 1'b0) e--;
    return {s, 8'(127 + e), 23'((m - (1 << e)) << (23 - e))};
  endfunction

  function automatic int lat16(input logic [15:0] x);
    int m;
    int e;
    if (x == 16'h0000) return 1;
    m = x[15] ? (65536 - int'(x)) : int'(x);
    e = 15;
    while (m[e] == 1'b0) e--;
    return (15 - e) + 2;
  endfunction

  task automatic wait_out16(input string name);
    exp_t e;
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      #1;
      if (out_valid) seen = 1'b1;
    end
    e = sb.pop_front();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no out_valid after %0d cycles, required value %h", name, n, e.val);
    end else begin
      if (floatout !== e.val) begin
        n_fail++;
        $display("FAIL %s value: got %h required %h", name, floatout, e.val);
      end
      n_tests++;
      if (n != e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
      end
    end
  endtask

  task automatic conv16(input logic [15:0] x, input logic [31:0] val, input int lat, input string name);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s in_ready: got 0 required 1", name);
      return;
    end
    sb.push_back('{val: val, lat: lat});
    intin = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out16(name);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int   n;
    logic bad;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || floatout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b f=%h required ov=0 ir=1 f=0", out_valid, in_ready, floatout);
    end
    @(negedge clk);
    intin = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || floatout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midnorm: got ov=%b ir=%b f=%h required ov=0 ir=1 f=0", out_valid, in_ready, floatout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_abort: got out_valid=1 after reset required 0");
    end
    conv16(16'h0001, 32'h3f800000, 17, "after_reset_0001");
  endtask

  task automatic test_values;
    conv16(16'h0000, 32'h00000000, 1,  "zero");
    conv16(16'h0001, 32'h3f800000, 17, "one");
    conv16(16'hffff, 32'hbf800000, 17, "minus_one");
    conv16(16'h016b, 32'h43b58000, 9,  "x016b");
    conv16(16'hfaad, 32'hc4aa6000, 7,  "xfaad");
    conv16(16'h7fff, 32'h46fffe00, 3,  "max_pos");
    conv16(16'h8000, 32'hc7000000, 2,  "max_neg");
  endtask

  task automatic test_random;
    logic [15:0] x;
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      conv16(x, model16(x), lat16(x), "random");
    end
  endtask

  task automatic test_backpressure;
    int          n;
    logic        bad;
    logic [31:0] held;
    out_ready = 1'b0;
    @(negedge clk);
    sb.push_back('{val: 32'h46fffe00, lat: 3});
    intin = 16'h7fff;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out16("bp_first");
    held = floatout;
    @(negedge clk);
    sb.push_back('{val: 32'hc4aa6000, lat: 7});
    intin = 16'hfaad;
    in_valid = 1'b1;
    bad = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (floatout !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: got f=%h ir=%b ov=%b required f=%h ir=0 ov=1", floatout, in_ready, out_valid, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_accept: got in_ready=%b required 0", in_ready);
    end
    wait_out16("bp_second");
    @(posedge clk); #1;
  endtask

  task automatic conv32(input logic [31:0] x, input logic [31:0] val, input int lat, input string name);
    int   n;
    logic seen;
    @(negedge clk);
    n = 0;
    while (!in_ready32 && n < 50) begin @(negedge clk); n++; end
    intin32 = x;
    in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); n++;
      #1;
      if (out_valid32) seen = 1'b1;
    end
    n_tests++;
    if (!seen || floatout32 !== val) begin
      n_fail++;
      $display("FAIL %s value: got %h (valid=%b) required %h", name, floatout32, seen, val);
    end
    n_tests++;
    if (n != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, n, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width32;
`ifdef ITOF_ROUND_EN
    conv32(32'h01000003, 32'h4b800002, 9, "w32_round_tie");
    conv32(32'h7fffffff, 32'h4f000000, 3, "w32_round_carry");
`else
    conv32(32'h01000003, 32'h4b800001, 9, "w32_trunc_tie");
    conv32(32'h7fffffff, 32'h4effffff, 3, "w32_trunc_max");
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    test_reset();
    test_values();
    test_random();
    test_backpressure();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
